// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: drives the PC, fetches over req/ack,
// resolves NOP/JMP/BZ/HALT locally and hands other opcodes to execute.
module fetch_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_q,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_d,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              zero_flag,
  output logic [DATA_W-1:0] ir,
  output logic              exec_valid,
  input  logic              exec_done,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        opc;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic              is_nop;
  logic              is_jmp;
  logic              is_bz;
  logic              is_hlt;

  assign opc     = ir[15:12];
  assign jmp_tgt = {{(ADDR_W-12){1'b0}}, ir[11:0]};
  assign br_off  = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
  // pc_q already points past the branch word, and the add wraps mod 2^ADDR_W
  assign br_tgt  = pc_q + br_off;

  assign is_nop = (opc == 4'h0);
  assign is_jmp = (opc == 4'hC);
  assign is_bz  = (opc == 4'hD);
  assign is_hlt = (opc == 4'hF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem_ack) begin
        ir <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_d       = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          pc_inc    = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_nop: state_nxt = FETCH;
          is_jmp: begin
            pc_ld     = 1'b1;
            pc_d      = jmp_tgt;
            state_nxt = FETCH;
          end
          is_bz: begin
            if (zero_flag) begin
              pc_ld = 1'b1;
              pc_d  = br_tgt;
            end
            state_nxt = FETCH;
          end
          is_hlt:  state_nxt = HALT;
          default: state_nxt = EXEC;
        endcase
      end
      EXEC: begin
        exec_valid = 1'b1;
        if (exec_done) state_nxt = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle vector table plus
// hand sequences for NOP streaming, wait states and async reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pc_q;
  logic        pc_ld;
  logic        pc_inc;
  logic [15:0] pc_d;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        zero_flag;
  logic [15:0] ir;
  logic        exec_valid;
  logic        exec_done;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pc_q      (pc_q),
    .pc_ld     (pc_ld),
    .pc_inc    (pc_inc),
    .pc_d      (pc_d),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .zero_flag (zero_flag),
    .ir        (ir),
    .exec_valid(exec_valid),
    .exec_done (exec_done),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [15:0] pcq;
    logic        ack;
    logic [15:0] rd;
    logic        zf;
    logic        dn;
    logic        ld;
    logic        inc;
    logic [15:0] pd;
    logic        req;
    logic [15:0] addr;
    logic [15:0] ir;
    logic        ev;
    logic        hl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic st, input logic [15:0] pcq,
                     input logic ack, input logic [15:0] rd,
                     input logic zf, input logic dn,
                     input logic ld, input logic inc,
                     input logic [15:0] pd, input logic req,
                     input logic [15:0] addr, input logic [15:0] irx,
                     input logic ev, input logic hl);
    vec_t v;
    v.st = st; v.pcq = pcq; v.ack = ack; v.rd = rd;
    v.zf = zf; v.dn = dn; v.ld = ld; v.inc = inc;
    v.pd = pd; v.req = req; v.addr = addr; v.ir = irx;
    v.ev = ev; v.hl = hl;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; pc_q = 0; mem_ack = 0; mem_rdata = 0;
    zero_flag = 0; exec_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    #1;
    chk("rst.req", {31'b0, mem_req}, 0);
    chk("rst.ir", {16'b0, ir}, 0);
    chk("rst.halted", {31'b0, halted}, 0);
    chk("rst.strobes", {pc_ld, pc_inc, exec_valid, pc_d, mem_addr}, 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int incs, lds, bad, cyc;
    logic [15:0] pc;
    reset = 1;
    idle_inputs();

    add(0,16'h0000,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'h0000,0,0);
    add(1,16'h0000,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'h0000,0,0);
    add(0,16'h0000,1,16'h0000,0,0, 0,1,16'h0000,1,16'h0000,16'h0000,0,0);
    add(0,16'h0001,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'h0000,0,0);
    add(0,16'h0001,1,16'hC123,0,0, 0,1,16'h0000,1,16'h0001,16'h0000,0,0);
    add(0,16'h0002,0,16'h0000,0,0, 1,0,16'h0123,0,16'h0000,16'hC123,0,0);
    add(0,16'h0123,1,16'hD0FE,0,0, 0,1,16'h0000,1,16'h0123,16'hC123,0,0);
    add(0,16'h0124,0,16'h0000,1,0, 1,0,16'h0122,0,16'h0000,16'hD0FE,0,0);
    add(0,16'h0122,1,16'hD0FE,0,0, 0,1,16'h0000,1,16'h0122,16'hD0FE,0,0);
    add(0,16'h0123,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'hD0FE,0,0);
    add(0,16'h0123,1,16'hD001,0,0, 0,1,16'h0000,1,16'h0123,16'hD0FE,0,0);
    add(0,16'hFFFF,0,16'h0000,1,0, 1,0,16'h0000,0,16'h0000,16'hD001,0,0);
    add(0,16'h0000,0,16'h0000,0,1, 0,0,16'h0000,1,16'h0000,16'hD001,0,0);
    add(0,16'h0000,0,16'h0000,0,1, 0,0,16'h0000,1,16'h0000,16'hD001,0,0);
    add(0,16'h0000,1,16'h1234,0,0, 0,1,16'h0000,1,16'h0000,16'hD001,0,0);
    add(0,16'h0001,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'h1234,0,0);
    add(0,16'h0001,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'h1234,1,0);
    add(0,16'h0001,1,16'h5555,0,1, 0,0,16'h0000,0,16'h0000,16'h1234,1,0);
    add(0,16'h0001,1,16'hF000,0,0, 0,1,16'h0000,1,16'h0001,16'h1234,0,0);
    add(0,16'h0002,0,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'hF000,0,0);
    add(1,16'h0002,1,16'h0000,0,0, 0,0,16'h0000,0,16'h0000,16'hF000,0,1);
    add(1,16'h0002,0,16'h0000,1,1, 0,0,16'h0000,0,16'h0000,16'hF000,0,1);

    do_reset();

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      start = tv[i].st; pc_q = tv[i].pcq; mem_ack = tv[i].ack;
      mem_rdata = tv[i].rd; zero_flag = tv[i].zf; exec_done = tv[i].dn;
      #1;
      chk($sformatf("v%0d.pc_ld", i), {31'b0, pc_ld}, {31'b0, tv[i].ld});
      chk($sformatf("v%0d.pc_inc", i), {31'b0, pc_inc}, {31'b0, tv[i].inc});
      chk($sformatf("v%0d.pc_d", i), {16'b0, pc_d}, {16'b0, tv[i].pd});
      chk($sformatf("v%0d.mem_req", i), {31'b0, mem_req}, {31'b0, tv[i].req});
      chk($sformatf("v%0d.mem_addr", i), {16'b0, mem_addr}, {16'b0, tv[i].addr});
      chk($sformatf("v%0d.ir", i), {16'b0, ir}, {16'b0, tv[i].ir});
      chk($sformatf("v%0d.exec_valid", i), {31'b0, exec_valid}, {31'b0, tv[i].ev});
      chk($sformatf("v%0d.halted", i), {31'b0, halted}, {31'b0, tv[i].hl});
    end

    // NOP stream with a bench-side PC model
    do_reset();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    pc = 16'h0000; incs = 0; lds = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      pc_q = pc; mem_ack = 1; mem_rdata = 16'h0000;
      #1;
      if (mem_req && mem_addr !== pc) bad++;
      if (pc_ld) lds++;
      if (pc_inc) begin
        incs++;
        pc = pc + 16'h1;
      end
      @(negedge clk);
    end
    chk("nop.incs", incs, 5);
    chk("nop.lds", lds, 0);
    chk("nop.addr", bad, 0);
    chk("nop.pc", {16'b0, pc}, 5);

    // wait-stated fetch of an ALU op, delayed exec_done, then reset mid-fetch
    do_reset();
    @(negedge clk);
    start = 1;
    pc_q = 16'h0040;
    @(negedge clk);
    start = 0;
    cyc = 0;
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 3);
      mem_rdata = (c == 3) ? 16'h1234 : 16'hFFFF;
      exec_done = (c == 1);
      #1;
      if (mem_req && mem_addr == 16'h0040) cyc++;
      @(negedge clk);
    end
    chk("ws.req_stable", cyc, 4);
    mem_ack = 0; exec_done = 0; pc_q = 16'h0041;
    #1;
    chk("ws.decode_ir", {16'b0, ir}, 32'h1234);
    chk("ws.decode_req", {31'b0, mem_req}, 0);
    @(negedge clk);
    cyc = 0;
    for (int c = 0; c < 5; c++) begin
      exec_done = (c == 4);
      #1;
      if (exec_valid && ir == 16'h1234) cyc++;
      @(negedge clk);
    end
    chk("ws.exec_cycles", cyc, 5);
    exec_done = 0;
    #1;
    chk("ws.refetch_req", {31'b0, mem_req}, 1);
    chk("ws.refetch_addr", {16'b0, mem_addr}, 32'h0041);
    reset = 1;
    #1;
    chk("ar.req", {31'b0, mem_req}, 0);
    chk("ar.ir", {16'b0, ir}, 0);
    chk("ar.halted", {31'b0, halted}, 0);
    @(negedge clk);
    reset = 0;
    mem_ack = 1;
    @(negedge clk);
    #1;
    chk("ar.idle_req", {31'b0, mem_req}, 0);
    chk("ar.idle_inc", {31'b0, pc_inc}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
